wfi_monitor_mc: RTL and testbench

Multi-hart, synthesizable WFI protocol monitor for the core testbench. It replaces per-hart `$fatal` checking with a per-hart state machine that does four things: checks `wfi` assertion against the retiring instruction stream, times out a missing assertion, bounds wake-up latency after an interrupt becomes pending, and reports errors through a registered error port plus sticky status. It sits beside the core, sampling the same retire and interrupt signals the bench already taps, and can be bound in simulation or kept in emulation builds.

---
 rtl/wfi_monitor_mc.sv | 153 +++++++++++++++
 tb/tb_wfi_monitor_mc.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wfi_monitor_mc.sv
// wfi_monitor_mc: per-hart WFI protocol checker with registered error reporting and sticky status
module wfi_monitor_mc #(
    parameter int          NHARTS     = 2,
    parameter int          SKIP_CNT   = 100,
    parameter int          WAKE_MAX   = 32,
    parameter int          CNTW       = 16,
    parameter logic [31:0] WFI_OPCODE = 32'h10500073,
    localparam int         HW         = NHARTS > 1 ? $clog2(NHARTS) : 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [NHARTS-1:0]        wfi,
    input  logic [NHARTS-1:0]        inst_vld,
    input  logic [32*NHARTS-1:0]     inst,
    input  logic [NHARTS-1:0]        irq_pend,
    input  logic [NHARTS-1:0]        allow_wfi,
    input  logic [NHARTS-1:0]        debug,
    input  logic [NHARTS-1:0]        step,
    input  logic [NHARTS-1:0]        excpt,
    output logic                     err_valid,
    output logic [HW-1:0]            err_hart,
    output logic [2:0]               err_code,
    output logic [4*NHARTS-1:0]      err_status,
    output logic [CNTW*NHARTS-1:0]   sleep_cnt,
    output logic [3*NHARTS-1:0]      state
);
    localparam int CW = $clog2(SKIP_CNT + 1);
    localparam int WW = $clog2(WAKE_MAX + 1);
    typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, SLEEP = 3'd2, WAKE = 3'd3, SKIP = 3'd4} state_t;
    logic [3*NHARTS-1:0] codes;
    logic [4*NHARTS-1:0] hit;
    for (genvar h = 0; h < NHARTS; h++) begin : g_hart
        state_t st, nst;
        logic [CW-1:0] cnt, ncnt;
        logic [WW-1:0] wcnt, nwcnt;
        logic [CNTW-1:0] scnt;
        logic [2:0] code;
        logic [4:0] oh;
        logic wfi_q, irq_q, wfi_inst, quiet, rise, fall, inc;
        assign quiet = !irq_pend[h] & !irq_q & !excpt[h] & allow_wfi[h] & !step[h] & !debug[h];
        assign rise = wfi[h] & !wfi_q;
        assign fall = !wfi[h] & wfi_q;
        assign codes[3*h +: 3] = code;
        assign oh = 5'b1 << code;
        assign hit[4*h +: 4] = oh[4:1];
        assign state[3*h +: 3] = st;
        assign sleep_cnt[CNTW*h +: CNTW] = scnt;
        always_comb begin
            nst = st;
            ncnt = cnt;
            nwcnt = wcnt;
            inc = 1'b0;
            code = 3'd0;
            if (!enable)
                nst = IDLE;
            else if (rise & !wfi_inst) begin
                code = 3'd1;
                nst = SKIP;
            end else begin
                case (st)
                    IDLE: if (wfi_inst) begin
                        nst = wfi[h] ? SLEEP : ARMED;
                        ncnt = '0;
                    end
                    ARMED: if (rise) nst = SLEEP;
                    else if (!wfi_inst) nst = IDLE;
                    else if (!quiet) nst = SKIP;
                    else begin
                        ncnt = cnt + 1'b1;
                        if (ncnt == CW'(SKIP_CNT)) begin
                            code = 3'd2;
                            nst = SKIP;
                        end
                    end
                    SLEEP: if (fall) begin
                        inc = 1'b1;
                        nst = SKIP;
                    end else if (irq_pend[h]) begin
                        nst = WAKE;
                        nwcnt = '0;
                    end
                    WAKE: if (fall) begin
                        inc = 1'b1;
                        nst = SKIP;
                    end else begin
                        nwcnt = wcnt + 1'b1;
                        if (nwcnt == WW'(WAKE_MAX)) begin
                            code = 3'd4;
                            nst = SKIP;
                        end
                    end
                    SKIP: if (!wfi_inst & !wfi[h]) nst = IDLE;
                    else if (rise) nst = SLEEP;
                    default: nst = IDLE;
                endcase
                // Asserting wfi with an interrupt already pending goes straight to the wake timer
                if (nst == SLEEP && rise && irq_pend[h]) begin
                    code = 3'd3;
                    nst = WAKE;
                    nwcnt = '0;
                end
            end
        end
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                st <= IDLE;
                cnt <= '0;
                wcnt <= '0;
                scnt <= '0;
                wfi_q <= 1'b0;
                irq_q <= 1'b0;
                wfi_inst <= 1'b0;
            end else begin
                st <= nst;
                cnt <= ncnt;
                wcnt <= nwcnt;
                wfi_q <= wfi[h];
                irq_q <= irq_pend[h];
                if (inst_vld[h]) wfi_inst <= inst[32*h +: 32] == WFI_OPCODE;
                if (inc && scnt != '1) scnt <= scnt + 1'b1;
            end
        end
    end
    logic any;
    logic [HW-1:0] sel_h;
    logic [2:0] sel_c;
    always_comb begin
        any = 1'b0;
        sel_h = '0;
        sel_c = 3'd0;
        for (int i = NHARTS - 1; i >= 0; i--) begin
            if (codes[3*i +: 3] != 3'd0) begin
                any = 1'b1;
                sel_h = HW'(i);
                sel_c = codes[3*i +: 3];
            end
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_valid <= 1'b0;
            err_hart <= '0;
            err_code <= 3'd0;
            err_status <= '0;
        end else begin
            err_valid <= any;
            err_hart <= sel_h;
            err_code <= sel_c;
            err_status <= err_status | hit;
        end
    end
endmodule

// File: tb/tb_wfi_monitor_mc.sv
// tb_wfi_monitor_mc: directed table plus hand sequences for the two-hart WFI monitor
module tb_wfi_monitor_mc;
    localparam logic [31:0] WFI = 32'h10500073;
    localparam logic [31:0] NOP = 32'h00000013;
    logic clock = 1'b0, reset_n = 1'b1, enable = 1'b1;
    logic [1:0] wfi = '0, inst_vld = '0, irq_pend = '0, allow_wfi = 2'b11, debug = '0, step = '0, excpt = '0;
    logic [63:0] inst = '0;
    logic err_valid;
    logic [0:0] err_hart;
    logic [2:0] err_code;
    logic [7:0] err_status;
    logic [31:0] sleep_cnt;
    logic [5:0] state;
    int tests = 0, fails = 0, errs;

    wfi_monitor_mc dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .wfi(wfi), .inst_vld(inst_vld),
        .inst(inst), .irq_pend(irq_pend), .allow_wfi(allow_wfi), .debug(debug), .step(step),
        .excpt(excpt), .err_valid(err_valid), .err_hart(err_hart), .err_code(err_code),
        .err_status(err_status), .sleep_cnt(sleep_cnt), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct {
        int n;
        logic [1:0] wfi, vld, irq;
        logic [31:0] i0, i1;
        logic [5:0] st;
        logic ev, hart;
        logic [2:0] code;
        logic [7:0] status;
        logic [15:0] sc0;
    } vec_t;
    vec_t tbl[14];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input int n, output int e);
        e = 0;
        repeat (n) begin
            tick();
            e += int'(err_valid);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b1;
        wfi = '0;
        inst_vld = '0;
        irq_pend = '0;
        inst = '0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic retire0();
        inst_vld = 2'b01;
        inst[31:0] = WFI;
        tick();
        inst_vld = '0;
    endtask

    initial begin
        tbl[0]  = '{1,  2'b00, 2'b01, 2'b00, WFI, NOP, 6'h00, 0, 0, 3'd0, 8'h00, 16'd0};
        tbl[1]  = '{1,  2'b00, 2'b00, 2'b00, WFI, NOP, 6'h01, 0, 0, 3'd0, 8'h00, 16'd0};
        tbl[2]  = '{10, 2'b00, 2'b00, 2'b00, WFI, NOP, 6'h01, 0, 0, 3'd0, 8'h00, 16'd0};
        tbl[3]  = '{1,  2'b01, 2'b00, 2'b00, WFI, NOP, 6'h02, 0, 0, 3'd0, 8'h00, 16'd0};
        tbl[4]  = '{19, 2'b01, 2'b00, 2'b00, WFI, NOP, 6'h02, 0, 0, 3'd0, 8'h00, 16'd0};
        tbl[5]  = '{1,  2'b00, 2'b00, 2'b00, WFI, NOP, 6'h04, 0, 0, 3'd0, 8'h00, 16'd1};
        tbl[6]  = '{1,  2'b00, 2'b01, 2'b00, NOP, NOP, 6'h04, 0, 0, 3'd0, 8'h00, 16'd1};
        tbl[7]  = '{1,  2'b00, 2'b00, 2'b00, NOP, NOP, 6'h00, 0, 0, 3'd0, 8'h00, 16'd1};
        tbl[8]  = '{1,  2'b00, 2'b10, 2'b00, NOP, NOP, 6'h00, 0, 0, 3'd0, 8'h00, 16'd1};
        tbl[9]  = '{1,  2'b10, 2'b00, 2'b00, NOP, NOP, 6'h20, 1, 1, 3'd1, 8'h10, 16'd1};
        tbl[10] = '{1,  2'b10, 2'b00, 2'b00, NOP, NOP, 6'h20, 0, 0, 3'd0, 8'h10, 16'd1};
        tbl[11] = '{1,  2'b00, 2'b00, 2'b00, NOP, NOP, 6'h00, 0, 0, 3'd0, 8'h10, 16'd1};
        tbl[12] = '{1,  2'b11, 2'b00, 2'b00, NOP, NOP, 6'h24, 1, 0, 3'd1, 8'h11, 16'd1};
        tbl[13] = '{1,  2'b00, 2'b00, 2'b00, NOP, NOP, 6'h00, 0, 0, 3'd0, 8'h11, 16'd1};

        #2 reset_n = 1'b0;
        tick();
        chk("rst.err_valid", 32'(err_valid), 0);
        chk("rst.err_code", 32'(err_code), 0);
        chk("rst.err_hart", 32'(err_hart), 0);
        chk("rst.err_status", 32'(err_status), 0);
        chk("rst.sleep_cnt", sleep_cnt, 0);
        chk("rst.state", 32'(state), 0);
        reset_n = 1'b1;
        tick();

        foreach (tbl[k]) begin
            wfi = tbl[k].wfi;
            inst_vld = tbl[k].vld;
            irq_pend = tbl[k].irq;
            inst = {tbl[k].i1, tbl[k].i0};
            repeat (tbl[k].n) tick();
            chk($sformatf("row%0d.state", k), 32'(state), 32'(tbl[k].st));
            chk($sformatf("row%0d.err_valid", k), 32'(err_valid), 32'(tbl[k].ev));
            chk($sformatf("row%0d.err_hart", k), 32'(err_hart), 32'(tbl[k].hart));
            chk($sformatf("row%0d.err_code", k), 32'(err_code), 32'(tbl[k].code));
            chk($sformatf("row%0d.err_status", k), 32'(err_status), 32'(tbl[k].status));
            chk($sformatf("row%0d.sleep_cnt0", k), 32'(sleep_cnt[15:0]), 32'(tbl[k].sc0));
        end

        // NOASSERT on exactly the 100th quiet armed cycle
        do_reset();
        retire0();
        tick();
        run(99, errs);
        chk("noassert.none_at_99", errs, 0);
        chk("noassert.armed_at_99", 32'(state), 6'h01);
        tick();
        chk("noassert.err_valid", 32'(err_valid), 1);
        chk("noassert.err_code", 32'(err_code), 2);
        chk("noassert.err_status", 32'(err_status), 8'h02);
        chk("noassert.state", 32'(state), 6'h04);

        // interrupt mid-way through the quiet window cancels the check
        do_reset();
        retire0();
        tick();
        errs = 0;
        for (int c = 1; c <= 110; c++) begin
            irq_pend = (c == 50) ? 2'b01 : 2'b00;
            tick();
            errs += int'(err_valid);
        end
        chk("irqskip.errors", errs, 0);
        chk("irqskip.err_status", 32'(err_status), 0);
        chk("irqskip.state", 32'(state), 6'h04);

        // WAKE_LATE on the 32nd cycle after entering WAKE
        do_reset();
        retire0();
        wfi = 2'b01;
        tick();
        chk("wakelate.sleep", 32'(state), 6'h02);
        irq_pend = 2'b01;
        tick();
        chk("wakelate.wake", 32'(state), 6'h03);
        run(31, errs);
        chk("wakelate.none_at_31", errs, 0);
        tick();
        chk("wakelate.err_valid", 32'(err_valid), 1);
        chk("wakelate.err_code", 32'(err_code), 4);
        chk("wakelate.err_status", 32'(err_status), 8'h08);

        // wake just in time: wfi falls on cycle 31
        do_reset();
        retire0();
        wfi = 2'b01;
        tick();
        irq_pend = 2'b01;
        tick();
        run(30, errs);
        wfi = 2'b00;
        tick();
        errs += int'(err_valid);
        chk("wakeok.errors", errs, 0);
        chk("wakeok.sleep_cnt0", 32'(sleep_cnt[15:0]), 1);
        chk("wakeok.state", 32'(state), 6'h04);

        // wfi asserted with interrupt already pending
        do_reset();
        retire0();
        wfi = 2'b01;
        irq_pend = 2'b01;
        tick();
        chk("assertpend.err_valid", 32'(err_valid), 1);
        chk("assertpend.err_code", 32'(err_code), 3);
        chk("assertpend.err_status", 32'(err_status), 8'h04);
        chk("assertpend.state", 32'(state), 6'h03);

        // simultaneous spurious, then reset in the middle of a sleep
        do_reset();
        wfi = 2'b11;
        tick();
        chk("dual.err_hart", 32'(err_hart), 0);
        chk("dual.err_code", 32'(err_code), 1);
        chk("dual.err_status", 32'(err_status), 8'h11);
        wfi = 2'b00;
        tick();
        retire0();
        wfi = 2'b01;
        tick();
        chk("midsleep.state", 32'(state), 6'h02);
        reset_n = 1'b0;
        wfi = 2'b00;
        #1;
        chk("midsleep.rst_state", 32'(state), 0);
        chk("midsleep.rst_status", 32'(err_status), 0);
        chk("midsleep.rst_err_valid", 32'(err_valid), 0);
        tick();
        reset_n = 1'b1;
        run(2, errs);
        chk("midsleep.no_error", errs, 0);
        chk("midsleep.idle", 32'(state), 0);

        // enable low forces IDLE and masks errors
        do_reset();
        retire0();
        tick();
        chk("enable.armed", 32'(state), 6'h01);
        enable = 1'b0;
        wfi = 2'b10;
        tick();
        chk("enable.idle", 32'(state), 0);
        chk("enable.no_err", 32'(err_valid), 0);
        enable = 1'b1;
        tick();
        chk("enable.rearm", 32'(state), 6'h01);
        chk("enable.status", 32'(err_status), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
